// File: rtl/tcam_match_engine.sv
// Two-stage ternary CAM lookup engine with valid/ready handshakes and lowest-index priority.
// Define TCAM_STATS_CNT_EN to build the saturating hit/miss statistics counters.
module tcam_match_engine #(
    parameter int                DEPTH      = 16,
    parameter int                ACT_W      = 8,
    parameter logic [ACT_W-1:0]  DEF_ACTION = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [127:0]                  tcam_key,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_hit,
    output logic [$clog2(DEPTH)-1:0]      res_index,
    output logic [ACT_W-1:0]              res_action,
    input  logic                          cfg_wr_en,
    input  logic [$clog2(DEPTH)-1:0]      cfg_addr,
    input  logic [127:0]                  cfg_value,
    input  logic [127:0]                  cfg_mask,
    input  logic [ACT_W-1:0]              cfg_action,
    input  logic                          cfg_entry_vld,
    input  logic                          cnt_clr,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int KEY_W = 128;

    logic                 s1_valid_r;
    logic [KEY_W-1:0]     s1_key_r;
    logic [KEY_W-1:0]     value_r  [DEPTH];
    logic [KEY_W-1:0]     mask_r   [DEPTH];
    logic [ACT_W-1:0]     action_r [DEPTH];
    logic [DEPTH-1:0]     entry_vld_r;

    logic                 key_accept_s;
    logic                 s2_load_s;
    logic [DEPTH-1:0]     match_s;
    logic                 hit_s;
    logic [IDX_W-1:0]     idx_s;
    logic [ACT_W-1:0]     act_s;

    // S2 can take the S1 key whenever its own result is absent or leaving this cycle.
    assign s2_load_s    = s1_valid_r && (!res_valid || res_ready);
    assign key_ready    = !(s1_valid_r && res_valid && !res_ready);
    assign key_accept_s = key_valid && key_ready;

    // Per-entry ternary compare of the S1 key against the current table.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = entry_vld_r[i] && (((s1_key_r ^ value_r[i]) & mask_r[i]) == '0);
        end
    end

    // Priority encoder: scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        hit_s = 1'b0;
        idx_s = '0;
        act_s = DEF_ACTION;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_s = hit_s | match_s[i];
            idx_s = match_s[i] ? IDX_W'(i) : idx_s;
            act_s = match_s[i] ? action_r[i] : act_s;
        end
    end

    // S1 occupancy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (key_accept_s) begin
            s1_valid_r <= 1'b1;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Unreset datapath storage: S1 key and the entry value/mask/action table.
    always_ff @(posedge clk) begin
        if (key_accept_s) begin
            s1_key_r <= tcam_key;
        end
        if (cfg_wr_en) begin
            value_r[cfg_addr]  <= cfg_value;
            mask_r[cfg_addr]   <= cfg_mask;
            action_r[cfg_addr] <= cfg_action;
        end
    end

    // Entry enables, cleared by reset so a reset table never matches stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_vld_r <= '0;
        end else if (cfg_wr_en) begin
            entry_vld_r[cfg_addr] <= cfg_entry_vld;
        end
    end

    // S2 result register; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_hit    <= 1'b0;
            res_index  <= '0;
            res_action <= '0;
        end else if (s2_load_s) begin
            res_valid  <= 1'b1;
            res_hit    <= hit_s;
            res_index  <= idx_s;
            res_action <= act_s;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

`ifdef TCAM_STATS_CNT_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Saturating statistics, counted on result transfer; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (cnt_clr) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (res_valid && res_ready) begin
            if (res_hit) begin
                if (hit_cnt_r != 32'hFFFF_FFFF) begin
                    hit_cnt_r <= hit_cnt_r + 32'd1;
                end
            end else if (miss_cnt_r != 32'hFFFF_FFFF) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;
`else
    logic cnt_clr_unused_s;

    assign cnt_clr_unused_s = cnt_clr;
    assign hit_count        = 32'd0;
    assign miss_count       = 32'd0;
`endif

endmodule
